mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL: clk_i  in  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  EX/MEM control bits.
REQ-004 SHALL: ALURet_i  in  32  memory address / ALU result; WriteData_i  in  32  store data; RDaddr_i  in  5  destination register.
REQ-005 SHALL: dmem_req_o  out  1  memory request; dmem_we_o  out  1  write enable; dmem_addr_o  out  32; dmem_wdata_o  out  32.
REQ-006 SHALL: dmem_ack_i  in  1  memory completion; dmem_rdata_i  in  32  load data, valid with dmem_ack_i.
REQ-007 SHALL: stall_o  out  1  combinational; holds EX/MEM and earlier stages while high.
REQ-008 SHALL: RegWrite_o, MemtoReg_o  out  1; RDaddr_o  out  5; ALURet_o, ReadData_o  out  32  registered MEM/WB fields.
REQ-009 SHALL: err_o  out  1  sticky memory-timeout flag.

Function
REQ-010 SHALL: two-state FSM, IDLE and WAIT; access = MemRead_i | MemWrite_i.
REQ-011 SHALL: IDLE, access=0: at next edge MEM/WB outputs load inputs (1-cycle latency), ReadData_o <= 0; stall_o=0.
REQ-012 SHALL: IDLE, access=1: stall_o=1; at edge latch addr=ALURet_i, wdata=WriteData_i, we=MemWrite_i, control/RDaddr; go WAIT; dmem_req_o <= 1; RegWrite_o <= 0 (bubble).
REQ-013 SHALL: MemRead_i and MemWrite_i both 1 -> treated as store (dmem_we_o=1).
REQ-014 SHALL: WAIT: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o held stable from latched values until ack.
REQ-015 SHALL: WAIT, dmem_ack_i=0: stall_o=1; RegWrite_o <= 0 each edge.
REQ-016 SHALL: WAIT, dmem_ack_i=1: stall_o=0; at edge MEM/WB outputs load latched fields, ReadData_o <= dmem_rdata_i for loads, 0 for stores; dmem_req_o <= 0; go IDLE.
REQ-017 SHALL: dmem_ack_i ignored in IDLE.
REQ-018 SHALL: minimum memory-op latency 2 cycles (ack on first WAIT cycle); one extra cycle per ack-low WAIT cycle.
REQ-019 SHALL: dmem_req_o never high in IDLE; a new request requires return to IDLE first (one IDLE cycle between back-to-back accesses).
REQ-020 SHALL: ALURet_o carries latched address for memory ops, ALURet_i otherwise.

Reset
REQ-021 SHALL: rst_i high -> immediately state=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, all MEM/WB outputs 0, err_o=0, timeout counter=0.
REQ-022 SHALL: rst_i asserted during WAIT aborts the access; request drops without waiting for ack; a late ack after release is ignored (IDLE).
REQ-023 SHALL: stall_o while rst_i high = 0.

Configuration
REQ-024 SHALL: macro MEM_ACCESS_TIMEOUT_EN present -> 8-bit counter cleared on entering WAIT, incremented each ack-low WAIT cycle.
REQ-025 SHALL: with macro, counter reaching 255 with ack low -> at that edge go IDLE, dmem_req_o <= 0, RegWrite_o <= 0, err_o <= 1 (sticky until reset), stall_o=0 that cycle.
REQ-026 SHALL: ack and count 255 same cycle -> ack wins, normal completion, err_o unchanged.
REQ-027 SHALL: macro absent -> no counter, WAIT indefinite, err_o tied 0.

Verification
REQ-028 SHALL: ALU op RegWrite_i=1, ALURet_i=0x0000_0010, RDaddr_i=5 in IDLE -> next cycle RegWrite_o=1, ALURet_o=0x10, RDaddr_o=5, stall_o never high.
REQ-029 SHALL: load addr 0x100, ack after 3 WAIT cycles with rdata 0xDEAD_BEEF -> stall_o high 4 cycles, dmem_req_o high 3+1 cycles, then ReadData_o=0xDEADBEEF, MemtoReg_o=1.
REQ-030 SHALL: store addr 0x200 data 0x1234_5678 with immediate ack -> dmem_we_o=1, dmem_wdata_o=0x12345678 one cycle, ReadData_o=0, total 2 cycles.
REQ-031 SHALL: rst_i pulsed in 2nd WAIT cycle of a load -> dmem_req_o=0 same cycle, all outputs 0, later ack ignored.
REQ-032 SHALL: with MEM_ACCESS_TIMEOUT_EN, load with ack never asserted -> after 255 WAIT cycles err_o=1, RegWrite_o=0, stall_o drops; without macro stall_o stays high at cycle 300.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/ack bus between the MEM stage and memory
interface mem_access_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with stalling memory handshake; optional timeout via MEM_ACCESS_TIMEOUT_EN
module mem_access_stage (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       RegWrite_i,
    input  logic                       MemtoReg_i,
    input  logic                       MemRead_i,
    input  logic                       MemWrite_i,
    input  logic [31:0]                ALURet_i,
    input  logic [31:0]                WriteData_i,
    input  logic [4:0]                 RDaddr_i,
    mem_access_stage_if.master         dmem,
    output logic                       stall_o,
    output logic                       RegWrite_o,
    output logic                       MemtoReg_o,
    output logic [4:0]                 RDaddr_o,
    output logic [31:0]                ALURet_o,
    output logic [31:0]                ReadData_o,
    output logic                       err_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        lat_rw_q, lat_rw_d;
    logic        lat_m2r_q, lat_m2r_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        access;
    logic        stall;
    logic        timeout_hit;

    assign access = MemRead_i | MemWrite_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Wait-cycle counter: held at zero in IDLE, counts ack-low WAIT cycles
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
        end else if (!dmem.dmem_ack_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This edge is the 255th ack-low WAIT cycle, so the count would reach 255
    assign timeout_hit = (cnt_q == 8'd254);
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, bus latch and MEM/WB field selection
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_rw_d  = lat_rw_q;
        lat_m2r_d = lat_m2r_q;
        lat_rd_d  = lat_rd_q;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    // Capture the access; a read+write pair is issued as a store
                    stall     = 1'b1;
                    state_d   = S_WAIT;
                    req_d     = 1'b1;
                    we_d      = MemWrite_i;
                    addr_d    = ALURet_i;
                    wdata_d   = WriteData_i;
                    lat_rw_d  = RegWrite_i;
                    lat_m2r_d = MemtoReg_i;
                    lat_rd_d  = RDaddr_i;
                    rw_d      = 1'b0;
                end else begin
                    rw_d    = RegWrite_i;
                    m2r_d   = MemtoReg_i;
                    rd_d    = RDaddr_i;
                    alu_d   = ALURet_i;
                    rdata_d = 32'd0;
                end
            end
            S_WAIT: begin
                if (dmem.dmem_ack_i) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    rw_d    = lat_rw_q;
                    m2r_d   = lat_m2r_q;
                    rd_d    = lat_rd_q;
                    alu_d   = addr_q;
                    rdata_d = we_q ? 32'd0 : dmem.dmem_rdata_i;
                end else if (timeout_hit) begin
                    // Abandon the access and release the pipeline with a bubble
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    rw_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    stall = 1'b1;
                    rw_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            lat_rw_q  <= 1'b0;
            lat_m2r_q <= 1'b0;
            lat_rd_q  <= 5'd0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            rd_q      <= 5'd0;
            alu_q     <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_rw_q  <= lat_rw_d;
            lat_m2r_q <= lat_m2r_d;
            lat_rd_q  <= lat_rd_d;
            rw_q      <= rw_d;
            m2r_q     <= m2r_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign stall_o           = stall & ~rst_i;
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign RegWrite_o        = rw_q;
    assign MemtoReg_o        = m2r_q;
    assign RDaddr_o          = rd_q;
    assign ALURet_o          = alu_q;
    assign ReadData_o        = rdata_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized pipeline/memory bench for mem_access_stage
module tb_mem_access_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALURet_i, WriteData_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, RegWrite_o, MemtoReg_o, err_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] ALURet_o, ReadData_o;

    mem_access_stage_if dmem ();

    mem_access_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALURet_i    (ALURet_i),
        .WriteData_i (WriteData_i),
        .RDaddr_i    (RDaddr_i),
        .dmem        (dmem.master),
        .stall_o     (stall_o),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .RDaddr_o    (RDaddr_o),
        .ALURet_o    (ALURet_o),
        .ReadData_o  (ReadData_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [0:15];
    int          idx, wait_left, next_delay, n_cyc, c_stall, c_req, c_we;
    bit          spur_en, retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_instr(input bit rw, input bit m2r, input bit mr, input bit mw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
        ALURet_i = alu; WriteData_i = wd; RDaddr_i = rd;
    endtask

    // One clock of the pipeline: memory responder, stall/bus rules, then retirement check
    task automatic do_cycle();
        bit          is_mem, exp_req, exp_stall, st;
        logic [31:0] e_rd;
        if (dmem.dmem_req_o === 1'b1 && idx == 1) wait_left = next_delay;
        if (dmem.dmem_req_o === 1'b1) begin
            if (wait_left == 0) begin
                dmem.dmem_ack_i   = 1'b1;
                dmem.dmem_rdata_i = dmem.dmem_we_o ? $urandom : mem[dmem.dmem_addr_o[5:2]];
            end else begin
                dmem.dmem_ack_i   = 1'b0;
                dmem.dmem_rdata_i = $urandom;
                wait_left--;
            end
        end else begin
            dmem.dmem_ack_i   = spur_en && ($urandom_range(0, 3) == 0);
            dmem.dmem_rdata_i = $urandom;
        end
        #1;
        is_mem    = MemRead_i | MemWrite_i;
        exp_req   = is_mem && (idx > 0);
        exp_stall = is_mem && (idx == 0 || !dmem.dmem_ack_i);
        chk("stall_o", stall_o, exp_stall);
        chk("dmem_req_o", dmem.dmem_req_o, exp_req);
        if (exp_req) begin
            chk("dmem_addr_o", dmem.dmem_addr_o, ALURet_i);
            chk("dmem_we_o", dmem.dmem_we_o, MemWrite_i);
            if (MemWrite_i) chk("dmem_wdata_o", dmem.dmem_wdata_o, WriteData_i);
        end
        if (stall_o) c_stall++;
        if (dmem.dmem_req_o) c_req++;
        if (dmem.dmem_req_o && dmem.dmem_we_o) c_we++;
        st   = stall_o;
        e_rd = (MemRead_i && !MemWrite_i) ? mem[ALURet_i[5:2]] : 32'd0;
        if (!st && MemWrite_i) mem[ALURet_i[5:2]] = WriteData_i;
        @(posedge clk_i); #1;
        n_cyc++;
        if (st) begin
            chk("RegWrite_o bubble", RegWrite_o, 1'b0);
        end else begin
            chk("RegWrite_o", RegWrite_o, RegWrite_i);
            chk("MemtoReg_o", MemtoReg_o, MemtoReg_i);
            chk("RDaddr_o", RDaddr_o, RDaddr_i);
            chk("ALURet_o", ALURet_o, ALURet_i);
            chk("ReadData_o", ReadData_o, e_rd);
        end
        chk("err_o", err_o, 1'b0);
        retired = !st;
        idx     = st ? idx + 1 : 0;
    endtask

    task automatic run_instr(input int delay);
        idx = 0; next_delay = delay; n_cyc = 0; c_stall = 0; c_req = 0; c_we = 0;
        retired = 1'b0;
        for (int k = 0; k < 400 && !retired; k++) do_cycle();
        if (!retired) chk("retire bound", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        spur_en = 1'b0;
        dmem.dmem_ack_i = 1'b0; dmem.dmem_rdata_i = 32'd0;
        set_instr(1, 1, 1, 0, 32'h40, 32'h0, 5'd3);
        rst_i = 1'b1;
        #12;
        chk("reset stall_o", stall_o, 1'b0);
        chk("reset req", dmem.dmem_req_o, 1'b0);
        chk("reset addr", dmem.dmem_addr_o, 32'd0);
        chk("reset RegWrite_o", RegWrite_o, 1'b0);
        chk("reset ReadData_o", ReadData_o, 32'd0);
        chk("reset err_o", err_o, 1'b0);
        set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ALU op passes through in one cycle
        set_instr(1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5);
        run_instr(0);
        chk("alu cycles", n_cyc, 1);
        chk("alu stall cycles", c_stall, 0);
        chk("alu RegWrite_o", RegWrite_o, 1'b1);
        chk("alu ALURet_o", ALURet_o, 32'h10);
        chk("alu RDaddr_o", RDaddr_o, 5'd5);

        // Load with three ack-low WAIT cycles
        mem[0] = 32'hDEAD_BEEF;
        set_instr(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7);
        run_instr(3);
        chk("load cycles", n_cyc, 5);
        chk("load stall cycles", c_stall, 4);
        chk("load req cycles", c_req, 4);
        chk("load ReadData_o", ReadData_o, 32'hDEAD_BEEF);
        chk("load MemtoReg_o", MemtoReg_o, 1'b1);

        // Store with immediate ack, then read it back
        set_instr(0, 0, 0, 1, 32'h0000_0200, 32'h1234_5678, 5'd0);
        run_instr(0);
        chk("store cycles", n_cyc, 2);
        chk("store we cycles", c_we, 1);
        chk("store ReadData_o", ReadData_o, 32'd0);
        set_instr(1, 1, 1, 0, 32'h0000_0200, 32'h0, 5'd9);
        run_instr(0);
        chk("readback ReadData_o", ReadData_o, 32'h1234_5678);

        // Randomized instruction stream with random ack latency and spurious idle acks
        spur_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 4);
            set_instr($urandom_range(0, 1), $urandom_range(0, 1),
                      kind == 1 || kind == 3, kind == 2 || kind == 3,
                      (kind >= 1 && kind <= 3) ? {26'd0, 4'($urandom_range(0, 15)), 2'b00} : $urandom,
                      $urandom, 5'($urandom_range(0, 31)));
            run_instr($urandom_range(0, 4));
        end
        spur_en = 1'b0;

        // Reset in the second WAIT cycle of a load aborts it; a late ack is ignored
        set_instr(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd4);
        idx = 0; next_delay = 1000;
        do_cycle();
        do_cycle();
        dmem.dmem_ack_i = 1'b0;
        #2; rst_i = 1'b1; #1;
        chk("abort req", dmem.dmem_req_o, 1'b0);
        chk("abort stall", stall_o, 1'b0);
        chk("abort we", dmem.dmem_we_o, 1'b0);
        chk("abort addr", dmem.dmem_addr_o, 32'd0);
        chk("abort RDaddr_o", RDaddr_o, 5'd0);
        chk("abort ALURet_o", ALURet_o, 32'd0);
        set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dmem.dmem_ack_i = 1'b1; dmem.dmem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        chk("late ack req", dmem.dmem_req_o, 1'b0);
        chk("late ack RegWrite_o", RegWrite_o, 1'b0);
        chk("late ack ReadData_o", ReadData_o, 32'd0);
        dmem.dmem_ack_i = 1'b0;
        idx = 0;

        // Load whose ack never arrives
        set_instr(1, 1, 1, 0, 32'h0000_0040, 32'h0, 5'd6);
        #1;
        chk("hang issue stall", stall_o, 1'b1);
        @(posedge clk_i); #1;
        for (int w = 1; w <= 300; w++) begin
            #1;
`ifdef MEM_ACCESS_TIMEOUT_EN
            chk("timeout stall", stall_o, w < 255);
            @(posedge clk_i); #1;
            if (w == 255) begin
                chk("timeout err_o", err_o, 1'b1);
                chk("timeout RegWrite_o", RegWrite_o, 1'b0);
                chk("timeout req", dmem.dmem_req_o, 1'b0);
                break;
            end
`else
            if (w == 300) chk("hang stall at 300", stall_o, 1'b1);
            chk("hang req", dmem.dmem_req_o, 1'b1);
            @(posedge clk_i); #1;
            if (w == 300) chk("hang err_o", err_o, 1'b0);
`endif
        end
        rst_i = 1'b1;
        set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("final err cleared", err_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
